// File: rtl/bin2bcd_if.sv
// Handshake and result bundle between a requester and the bin2bcd_seq converter.
//
// Handshake: the requester raises start with bin valid. The converter accepts it
// on a clock edge only while it is idle (busy low). After acceptance bin may
// change freely. busy stays high for the whole conversion. A start seen while
// busy is dropped, not queued. done is a one-cycle pulse that never overlaps
// busy. In the done cycle dig0..dig3 and ovf already carry the new result, and
// they hold that result until the next done. A start in the done cycle is
// accepted, so holding start high gives back-to-back conversions.
interface bin2bcd_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       dig0;
  logic [3:0]       dig1;
  logic [3:0]       dig2;
  logic [3:0]       dig3;

  modport master (
    output start, bin,
    input  busy, done, ovf, dig0, dig1, dig2, dig3
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, dig0, dig1, dig2, dig3
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// It converts one input bit per clock, and its digit outputs change only when a
// conversion completes. Inputs above MAX_VAL are clamped to MAX_VAL and flagged
// through ovf.
module bin2bcd_seq #(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic       clock,
  input  logic       reset,
  bin2bcd_if.slave   bus,
  output logic [1:0] o_dbg_state
);

  localparam int                CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  L_CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  L_CNT_LAST = CNT_W'(1);
  localparam logic [WIDTH-1:0]  L_CLAMP    = WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_shift;
  logic [15:0]      r_scratch;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pending;

  logic [3:0]       r_dig0;
  logic [3:0]       r_dig1;
  logic [3:0]       r_dig2;
  logic [3:0]       r_dig3;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;

  logic             w_accept;
  logic             w_over;
  logic [WIDTH-1:0] w_bin_clamped;
  logic [15:0]      w_adj;

  // The range check is done in 32 bits so that a MAX_VAL wider than WIDTH still
  // compares correctly. With narrow WIDTH the clamp can simply never trigger.
  always_comb begin
    w_over        = (32'(bus.bin) > 32'(MAX_VAL));
    w_bin_clamped = w_over ? L_CLAMP : bus.bin;
  end

  // Add-3 correction. Every nibble of 5 or more gets 3 added. All four nibbles
  // use the pre-shift scratch, so the following shift doubles into valid BCD.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < 4; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. The counter holds the number of shifts still to do, so
  // the last shift is the one taken while it reads 1.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == L_CNT_LAST) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, then do one add-3 and shift step per SHIFT cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift       <= '0;
      r_scratch     <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift       <= w_bin_clamped;
        r_scratch     <= '0;
        r_cnt         <= L_CNT_LOAD;
        r_ovf_pending <= w_over;
      end else if (r_state == SHIFT) begin
        r_scratch <= {w_adj[14:0], r_shift[WIDTH-1]};
        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
        r_cnt     <= r_cnt - 1'b1;
      end
    end
  end

  // Result registers. The digits and ovf update only in DONE, so the display
  // never sees a partial value. done is a one-cycle pulse. busy is high in
  // every cycle the FSM spends outside IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dig0 <= 4'h0;
      r_dig1 <= 4'h0;
      r_dig2 <= 4'h0;
      r_dig3 <= 4'h0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      r_busy <= (w_next_state != IDLE);
      if (r_state == DONE) begin
        r_dig0 <= r_scratch[3:0];
        r_dig1 <= r_scratch[7:4];
        r_dig2 <= r_scratch[11:8];
        r_dig3 <= r_scratch[15:12];
        r_ovf  <= r_ovf_pending;
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ovf     = r_ovf;
  assign bus.dig0    = r_dig0;
  assign bus.dig1    = r_dig1;
  assign bus.dig2    = r_dig2;
  assign bus.dig3    = r_dig3;
  assign o_dbg_state = r_state;

  // Invariants of the converter: done and busy are exclusive, and both the
  // scratch and the published digits are always valid BCD.
  a_done_not_busy : assert property (@(posedge clock) disable iff (reset)
    !(r_done && r_busy));
  a_scratch_bcd : assert property (@(posedge clock) disable iff (reset)
    (r_scratch[3:0] <= 4'd9) && (r_scratch[7:4] <= 4'd9) &&
    (r_scratch[11:8] <= 4'd9) && (r_scratch[15:12] <= 4'd9));
  a_digits_bcd : assert property (@(posedge clock) disable iff (reset)
    (r_dig0 <= 4'd9) && (r_dig1 <= 4'd9) && (r_dig2 <= 4'd9) && (r_dig3 <= 4'd9));

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq (WIDTH = 14): table-driven conversions plus
// hand-written multi-cycle sequences (start while busy, start held high,
// reset mid-conversion).
module tb_bin2bcd_seq;

  localparam int WIDTH = 14;
  localparam int LAT   = WIDTH + 2;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  int n_cmp;
  int n_bad;
  int cyc;

  logic [16:0] exp_q[$];
  vec_t        vecs[16];

  bin2bcd_if #(.WIDTH(WIDTH)) bus ();

  bin2bcd_seq #(.WIDTH(WIDTH), .MAX_VAL(9999)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Advance to the next falling edge and run the scoreboard on any done pulse.
  task automatic tick();
    logic [16:0] e;
    @(negedge clock);
    cyc++;
    if (bus.done === 1'b1) begin
      check("done_busy_excl", {31'd0, bus.busy}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done @cyc %0d: got done=1 expected no pending result", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result_digits", {16'd0, bus.dig3, bus.dig2, bus.dig1, bus.dig0}, {16'd0, e[16:1]});
        check("result_ovf", {31'd0, bus.ovf}, {31'd0, e[0]});
      end
    end
  endtask

  // One conversion. Cycle 0 is the cycle in which start is sampled high. When
  // poke > 0, a stray start with bin=1111 is pulsed in cycle poke.
  task automatic run_one(input logic [13:0] v, input logic [15:0] bcd, input logic ovf,
                         input int poke);
    bus.start = 1'b1;
    bus.bin   = v;
    exp_q.push_back({bcd, ovf});
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == 1) begin
        bus.start = 1'b0;
        bus.bin   = 14'($urandom_range(0, 16383));
      end
      if (poke > 0 && k == poke) begin
        bus.start = 1'b1;
        bus.bin   = 14'd1111;
      end
      if (poke > 0 && k == poke + 1) bus.start = 1'b0;
      check("busy_window", {31'd0, bus.busy}, {31'd0, (k <= WIDTH + 1)});
      check("done_timing", {31'd0, bus.done}, {31'd0, (k == LAT)});
    end
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;

    vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
    vecs[1]  = '{14'd0,     16'h0000, 1'b0};
    vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[3]  = '{14'd10000, 16'h9999, 1'b1};
    vecs[4]  = '{14'd16383, 16'h9999, 1'b1};
    vecs[5]  = '{14'd42,    16'h0042, 1'b0};
    vecs[6]  = '{14'd1,     16'h0001, 1'b0};
    vecs[7]  = '{14'd9,     16'h0009, 1'b0};
    vecs[8]  = '{14'd10,    16'h0010, 1'b0};
    vecs[9]  = '{14'd99,    16'h0099, 1'b0};
    vecs[10] = '{14'd100,   16'h0100, 1'b0};
    vecs[11] = '{14'd999,   16'h0999, 1'b0};
    vecs[12] = '{14'd1000,  16'h1000, 1'b0};
    vecs[13] = '{14'd5555,  16'h5555, 1'b0};
    vecs[14] = '{14'd8191,  16'h8191, 1'b0};
    vecs[15] = '{14'd2047,  16'h2047, 1'b0};

    // Reset state.
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (2) tick();
    check("rst_digits", {16'd0, bus.dig3, bus.dig2, bus.dig1, bus.dig0}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_after_rst", {31'd0, bus.busy}, 32'd0);

    // Table-driven conversions.
    for (int i = 0; i < 16; i++) begin
      run_one(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 0);
    end

    // A start while busy is ignored and the digits then hold.
    run_one(14'd5678, 16'h5678, 1'b0, 5);
    repeat (LAT + 4) begin
      tick();
      check("no_second_busy", {31'd0, bus.busy}, 32'd0);
    end
    check("hold_digits", {16'd0, bus.dig3, bus.dig2, bus.dig1, bus.dig0}, 32'h5678);

    // start held high: back-to-back conversions every LAT cycles.
    bus.start = 1'b1;
    bus.bin   = 14'd100;
    exp_q.push_back({16'h0100, 1'b0});
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      tick();
      if (k == 1) begin
        bus.bin = 14'd8;
        exp_q.push_back({16'h0008, 1'b0});
      end
      check("hold_busy", {31'd0, bus.busy},
            {31'd0, ((k >= 1 && k <= LAT - 1) || (k >= LAT + 1 && k <= 2 * LAT - 1))});
      check("hold_done", {31'd0, bus.done}, {31'd0, (k == LAT || k == 2 * LAT)});
      if (k == 2 * LAT) bus.start = 1'b0;
    end
    check("hold_drained", exp_q.size(), 32'd0);

    // Reset mid-conversion aborts immediately.
    run_one(14'd1234, 16'h1234, 1'b0, 0);
    bus.start = 1'b1;
    bus.bin   = 14'd4321;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) bus.start = 1'b0;
    end
    check("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_digits", {16'd0, bus.dig3, bus.dig2, bus.dig1, bus.dig0}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_ovf", {31'd0, bus.ovf}, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (LAT + 2) begin
      tick();
      check("post_abort_idle", {31'd0, bus.busy}, 32'd0);
      check("post_abort_nodone", {31'd0, bus.done}, 32'd0);
    end
    run_one(14'd4321, 16'h4321, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
